// File: rtl/clk_tick_pkg.sv
// Shared types and constants for the tick-driven BCD counter and its display decoders.
package clk_tick_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam seg_t SEG_OFF  = 7'h7F;
    localparam seg_t SEG_ZERO = 7'h40;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
module bcd_to_7seg
    import clk_tick_pkg::*;
(
    input  bcd_t digit,
    output seg_t seg
);

    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Turns rising edges of the divided clock into fast-domain ticks that drive a
// run/hold two-digit BCD up/down counter with programmable wrap and 7-seg decode.
//
//   state | meaning
//   IDLE  | count held at 00, waiting for i_start
//   RUN   | ticks advance the count in the i_up_down direction
//   HOLD  | count frozen, i_start resumes
module tick_bcd_counter
    import clk_tick_pkg::*;
#(
    parameter int MAX_COUNT   = 59,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk_FPGA,
    input  logic       i_reset,
    input  logic       i_clk_div,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_clear,
    input  logic       i_up_down,
    output logic [3:0] o_units,
    output logic [3:0] o_tens,
    output logic [6:0] o_seg_units,
    output logic [6:0] o_seg_tens,
    output logic       o_tc,
    output logic       o_running
);

    localparam bcd_t MAX_TENS  = bcd_t'(MAX_COUNT / 10);
    localparam bcd_t MAX_UNITS = bcd_t'(MAX_COUNT % 10);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;
    state_t                 state_q;
    bcd_t                   units_q, tens_q;
    bcd_t                   units_nxt, tens_nxt;
    logic                   wrap;

    // History is cleared together with the synchroniser so a reset drops any pending edge.
    always_ff @(posedge i_clk_FPGA) begin
        if (i_reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_clk_div};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_comb begin
        units_nxt = units_q;
        tens_nxt  = tens_q;
        wrap      = 1'b0;
        if (i_up_down) begin
            if (units_q == MAX_UNITS && tens_q == MAX_TENS) begin
                units_nxt = '0;
                tens_nxt  = '0;
                wrap      = 1'b1;
            end else if (units_q == 4'd9) begin
                units_nxt = '0;
                tens_nxt  = tens_q + 4'd1;
            end else begin
                units_nxt = units_q + 4'd1;
            end
        end else begin
            if (units_q == 4'd0 && tens_q == 4'd0) begin
                units_nxt = MAX_UNITS;
                tens_nxt  = MAX_TENS;
                wrap      = 1'b1;
            end else if (units_q == 4'd0) begin
                units_nxt = 4'd9;
                tens_nxt  = tens_q - 4'd1;
            end else begin
                units_nxt = units_q - 4'd1;
            end
        end
    end

    // A held i_start while already running must not block counting, so it only acts outside RUN.
    always_ff @(posedge i_clk_FPGA) begin
        if (i_reset) begin
            state_q   <= IDLE;
            units_q   <= '0;
            tens_q    <= '0;
            o_tc      <= 1'b0;
            o_running <= 1'b0;
        end else begin
            o_tc <= 1'b0;
            if (i_clear) begin
                state_q   <= IDLE;
                units_q   <= '0;
                tens_q    <= '0;
                o_running <= 1'b0;
            end else if (i_stop) begin
                if (state_q == RUN) begin
                    state_q   <= HOLD;
                    o_running <= 1'b0;
                end
            end else if (i_start && state_q != RUN) begin
                state_q   <= RUN;
                o_running <= 1'b1;
            end else if (state_q == RUN && tick) begin
                units_q <= units_nxt;
                tens_q  <= tens_nxt;
                o_tc    <= wrap;
            end
        end
    end

    assign o_units = units_q;
    assign o_tens  = tens_q;

    bcd_to_7seg u_seg_units (
        .digit (units_q),
        .seg   (o_seg_units)
    );

    bcd_to_7seg u_seg_tens (
        .digit (tens_q),
        .seg   (o_seg_tens)
    );

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter: vector table plus hand-written corner sequences.
module tb_tick_bcd_counter;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_clk_div = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_up_down = 1'b1;
    logic [3:0] o_units, o_tens;
    logic [6:0] o_seg_units, o_seg_tens;
    logic       o_tc, o_running;

    tick_bcd_counter #(.MAX_COUNT(59), .SYNC_STAGES(2)) dut (
        .i_clk_FPGA  (clk),
        .i_reset     (i_reset),
        .i_clk_div   (i_clk_div),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_clear     (i_clear),
        .i_up_down   (i_up_down),
        .o_units     (o_units),
        .o_tens      (o_tens),
        .o_seg_units (o_seg_units),
        .o_seg_tens  (o_seg_tens),
        .o_tc        (o_tc),
        .o_running   (o_running)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int tc_pulses = 0;
    int tc_long = 0;
    bit tc_prev = 1'b0;

    bit [6:0] seg_lut [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(negedge clk) begin
        if (o_tc) tc_pulses++;
        if (o_tc && tc_prev) tc_long++;
        tc_prev = o_tc;
    end

    typedef struct {
        bit start;
        bit stop;
        bit clear;
        bit up_down;
        int pulses;
        int value;
        bit running;
        int tcs;
    } vec_t;

    typedef struct {
        string name;
        int    value;
        bit    running;
        int    tc_base;
        int    tcs;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_div(input int n);
        if (n == 0) step(2);
        for (int p = 0; p < n; p++) begin
            i_clk_div = 1'b1;
            step(3);
            i_clk_div = 1'b0;
            step(3);
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input int value, input bit running, input int tcs);
        exp_t e;
        e.name = name;
        e.value = value;
        e.running = running;
        e.tc_base = tc_pulses;
        e.tcs = tcs;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            cmp({e.name, "_units"}, int'(o_units), e.value % 10);
            cmp({e.name, "_tens"}, int'(o_tens), e.value / 10);
            cmp({e.name, "_seg_units"}, int'(o_seg_units), int'(seg_lut[e.value % 10]));
            cmp({e.name, "_seg_tens"}, int'(o_seg_tens), int'(seg_lut[e.value / 10]));
            cmp({e.name, "_running"}, int'(o_running), int'(e.running));
            cmp({e.name, "_tc_count"}, tc_pulses - e.tc_base, e.tcs);
        end
    endtask

    task automatic run_pulses(input string name, input bit up, input int n,
                              input int value, input bit running, input int tcs);
        push_exp(name, value, running, tcs);
        i_up_down = up;
        pulse_div(n);
        check_pop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            start stop clear up pulses value run tcs
        vecs[0]  = '{1, 0, 0, 1, 5,  5, 1, 0};
        vecs[1]  = '{0, 0, 0, 1, 4,  9, 1, 0};
        vecs[2]  = '{0, 0, 0, 1, 1, 10, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1,  9, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 3,  6, 1, 0};
        vecs[5]  = '{0, 1, 0, 1, 3,  6, 0, 0};
        vecs[6]  = '{1, 1, 0, 1, 2,  6, 0, 0};
        vecs[7]  = '{1, 0, 0, 1, 6, 12, 1, 0};
        vecs[8]  = '{0, 0, 1, 1, 2,  0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 2,  0, 0, 0};
        vecs[10] = '{1, 1, 0, 1, 0,  0, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 1, 59, 1, 1};

        step(1);
        cmp("reset_units", int'(o_units), 0);
        cmp("reset_tens", int'(o_tens), 0);
        cmp("reset_tc", int'(o_tc), 0);
        cmp("reset_running", int'(o_running), 0);
        cmp("reset_seg_units", int'(o_seg_units), 'h40);
        cmp("reset_seg_tens", int'(o_seg_tens), 'h40);
        step(1);
        i_reset = 1'b0;
        step(1);

        for (int i = 0; i < 12; i++) begin
            push_exp($sformatf("vec%0d", i), vecs[i].value, vecs[i].running, vecs[i].tcs);
            i_start = vecs[i].start;
            i_stop = vecs[i].stop;
            i_clear = vecs[i].clear;
            i_up_down = vecs[i].up_down;
            pulse_div(vecs[i].pulses);
            i_start = 1'b0;
            i_stop = 1'b0;
            i_clear = 1'b0;
            step(1);
            check_pop();
        end

        // Wrap both ways around MAX_COUNT=59
        run_pulses("dn_to_58", 1'b0, 1, 58, 1'b1, 0);
        run_pulses("up_to_59", 1'b1, 1, 59, 1'b1, 0);
        run_pulses("up_wrap", 1'b1, 1, 0, 1'b1, 1);
        run_pulses("dn_wrap", 1'b0, 1, 59, 1'b1, 1);
        run_pulses("dn_58", 1'b0, 1, 58, 1'b1, 0);

        // Level held high for 100 cycles counts once
        push_exp("held_high", 59, 1'b1, 0);
        i_up_down = 1'b1;
        i_clk_div = 1'b1;
        step(100);
        i_clk_div = 1'b0;
        step(4);
        check_pop();

        // Clear arriving in the same cycle as a tick
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        run_pulses("to_37", 1'b1, 37, 37, 1'b1, 0);
        push_exp("clear_on_tick", 0, 1'b0, 0);
        i_clk_div = 1'b1;
        step(2);
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        i_clk_div = 1'b0;
        step(4);
        check_pop();

        // Reset in the middle of a run
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        run_pulses("to_03", 1'b1, 3, 3, 1'b1, 0);
        push_exp("reset_mid_run", 0, 1'b0, 0);
        i_clk_div = 1'b1;
        step(1);
        i_reset = 1'b1;
        step(1);
        check_pop();
        i_reset = 1'b0;
        i_clk_div = 1'b0;
        step(4);

        cmp("tc_single_cycle", tc_long, 0);
        cmp("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
